secuenciador_barrido: RTL and testbench



---
 rtl/secuenciador_barrido_if.sv | 25 ++
 rtl/secuenciador_barrido.sv | 128 ++++++++++++
 tb/tb_secuenciador_barrido.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/secuenciador_barrido_if.sv
// Control/status bundle between a scan controller and the sweep sequencer.
interface secuenciador_barrido_if #(
  parameter int DWELL_W = 16
);
  logic               start;
  logic               stop;
  logic               continuous;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         D;
  logic               en;
  logic               busy;
  logic               done;
  logic               wrap;

  modport master (
    output start, stop, continuous, mask, dwell,
    input  D, en, busy, done, wrap
  );

  modport slave (
    input  start, stop, continuous, mask, dwell,
    output D, en, busy, done, wrap
  );
endinterface

// File: rtl/secuenciador_barrido.sv
// Sweep sequencer: walks the set bits of a latched channel mask, low to high,
// holding each channel for dwell+1 cycles, driving a 3-to-8 decoder's D/en.
module secuenciador_barrido #(
  parameter int DWELL_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  secuenciador_barrido_if.slave bus
);
  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state_q, state_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               cont_q, cont_d;
  logic [2:0]         d_q, d_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) lowest = 3'(i);
  endfunction

  // Nearest set bit strictly above cur; bit 3 flags that one exists.
  function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
    next_above = 4'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i] && (3'(i) > cur)) next_above = {1'b1, 3'(i)};
  endfunction

  logic [3:0] nxt;
  assign nxt = next_above(mask_q, d_q);

  // State and output registers; reset also drops any scan in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      cont_q  <= 1'b0;
      d_q     <= 3'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      d_q     <= d_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next state: start/latch in IDLE, dwell counting and channel stepping in SCAN.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    cont_d  = cont_q;
    d_d     = d_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          mask_d  = bus.mask;
          dwell_d = bus.dwell;
          cont_d  = bus.continuous;
          cnt_d   = '0;
          if (bus.mask != 8'd0) begin
            state_d = SCAN;
            d_d     = lowest(bus.mask);
            en_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      SCAN: begin
        if (bus.stop) begin
          // Abort wins over a same-cycle dwell expiry: no done, no wrap.
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (nxt[3]) begin
            d_d = nxt[2:0];
          end else if (!cont_q) begin
            state_d = IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            d_d    = lowest(mask_q);
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.D    = d_q;
  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_secuenciador_barrido.sv
// Bench for the sweep sequencer: a vector table, directed sequences and
// random sweeps checked against a cycle-index model of the sweep.
module tb_secuenciador_barrido;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  secuenciador_barrido_if #(.DWELL_W(16)) bus ();
  secuenciador_barrido #(.DWELL_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic        start, stop, cont;
    logic [7:0]  mask;
    logic [15:0] dwell;
    logic [2:0]  d;
    logic        en, busy, done, wrap;
  } vec_t;

  vec_t vec [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [2:0] d, input logic en, input logic busy,
                     input logic done, input logic wrap, input bit use_d);
    checks++;
    if ((use_d && bus.D !== d) || bus.en !== en || bus.busy !== busy ||
        bus.done !== done || bus.wrap !== wrap) begin
      failures++;
      $display("FAIL %s: got D=%0d en=%b busy=%b done=%b wrap=%b, want D=%0d en=%b busy=%b done=%b wrap=%b",
               nm, bus.D, bus.en, bus.busy, bus.done, bus.wrap, d, en, busy, done, wrap);
    end
  endtask

  // Position of the n-th set bit of m (n counted from 0).
  function automatic int nth_bit(input logic [7:0] m, input int n);
    int c = 0;
    for (int i = 0; i < 8; i++)
      if (m[i]) begin
        if (c == n) return i;
        c++;
      end
    return 0;
  endfunction

  // Start one sweep and follow it cycle by cycle; stop_at<0 means never stop.
  task automatic sweep(input string nm, input logic [7:0] m, input logic [15:0] dw,
                       input bit c, input int stop_at);
    int n, len, k, ch;
    bit stopped;
    n = $countones(m);
    len = n * (int'(dw) + 1);
    bus.mask = m; bus.dwell = dw; bus.continuous = c; bus.start = 1'b1; bus.stop = 1'b0;
    tick();
    bus.start = 1'b0;
    // Scrambled inputs during the scan must not matter.
    bus.mask = 8'($urandom); bus.dwell = 16'($urandom); bus.continuous = 1'($urandom);
    if (n == 0) begin
      chk({nm, "_empty"}, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk({nm, "_empty_end"}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      return;
    end
    k = 0;
    stopped = 1'b0;
    ch = 0;
    forever begin
      if (stop_at >= 0 && k > stop_at) begin stopped = 1'b1; break; end
      if (!c && k == len) break;
      ch = nth_bit(m, (k % len) / (int'(dw) + 1));
      chk({nm, "_scan"}, 3'(ch), 1'b1, 1'b1, 1'b0, c && k > 0 && (k % len) == 0, 1'b1);
      bus.start = 1'($urandom);
      bus.stop = (k == stop_at);
      tick();
      k++;
    end
    bus.start = 1'b0;
    bus.stop = 1'b0;
    if (stopped) begin
      chk({nm, "_stop"}, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      chk({nm, "_done"}, 3'(ch), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      chk({nm, "_done_end"}, 3'(ch), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    //          start stop cont mask   dwell  D  en busy done wrap
    vec[0]  = '{1, 1, 0, 8'hFF, 16'd0, 3'd0, 0, 0, 0, 0}; // start+stop: nothing
    vec[1]  = '{1, 0, 0, 8'h00, 16'd0, 3'd0, 0, 0, 1, 0}; // empty mask: done
    vec[2]  = '{0, 0, 0, 8'h00, 16'd0, 3'd0, 0, 0, 0, 0};
    vec[3]  = '{1, 0, 0, 8'hA4, 16'd2, 3'd2, 1, 1, 0, 0}; // sparse sweep
    vec[4]  = '{1, 0, 1, 8'hFF, 16'd0, 3'd2, 1, 1, 0, 0}; // ignored in SCAN
    vec[5]  = '{0, 0, 0, 8'hFF, 16'd0, 3'd2, 1, 1, 0, 0};
    vec[6]  = '{0, 0, 0, 8'hFF, 16'd0, 3'd5, 1, 1, 0, 0};
    vec[7]  = '{0, 0, 0, 8'hFF, 16'd0, 3'd5, 1, 1, 0, 0};
    vec[8]  = '{0, 0, 0, 8'hFF, 16'd0, 3'd5, 1, 1, 0, 0};
    vec[9]  = '{0, 0, 0, 8'hFF, 16'd0, 3'd7, 1, 1, 0, 0};
    vec[10] = '{0, 0, 0, 8'hFF, 16'd0, 3'd7, 1, 1, 0, 0};
    vec[11] = '{0, 0, 0, 8'hFF, 16'd0, 3'd7, 1, 1, 0, 0};
    vec[12] = '{0, 0, 0, 8'hFF, 16'd0, 3'd7, 0, 0, 1, 0}; // single sweep ends
    vec[13] = '{1, 0, 0, 8'h81, 16'd0, 3'd0, 1, 1, 0, 0}; // start in done cycle
    vec[14] = '{0, 1, 0, 8'h81, 16'd0, 3'd0, 0, 0, 0, 0}; // stop on expiry
    vec[15] = '{0, 0, 0, 8'h00, 16'd0, 3'd0, 0, 0, 0, 0};

    bus.start = 1'b1; bus.stop = 1'b0; bus.continuous = 1'b0;
    bus.mask = 8'hFF; bus.dwell = 16'd0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    bus.start = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("after_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    for (int i = 0; i < 16; i++) begin
      bus.start = vec[i].start; bus.stop = vec[i].stop; bus.continuous = vec[i].cont;
      bus.mask = vec[i].mask; bus.dwell = vec[i].dwell;
      tick();
      chk($sformatf("vec%0d", i), vec[i].d, vec[i].en, vec[i].busy, vec[i].done, vec[i].wrap, 1'b1);
    end
    bus.start = 1'b0; bus.stop = 1'b0;

    sweep("full", 8'hFF, 16'd0, 1'b0, -1);
    sweep("cont", 8'h81, 16'd1, 1'b1, 6);
    sweep("long_dwell", 8'h90, 16'd300, 1'b0, -1);
    sweep("stop_last", 8'h18, 16'd1, 1'b0, 3);

    // Reset in the middle of a scan.
    bus.mask = 8'hFF; bus.dwell = 16'd3; bus.continuous = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("pre_reset_scan", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    chk("reset_mid_scan", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_after_abort", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    for (int it = 0; it < 40; it++) begin
      logic [7:0] m;
      logic [15:0] dw;
      bit c;
      int len, sa;
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      dw = 16'($urandom_range(0, 3));
      c = 1'($urandom_range(0, 1));
      len = $countones(m) * (int'(dw) + 1);
      if (c) sa = $urandom_range(0, 3 * len + 2);
      else if (len > 0 && $urandom_range(0, 3) == 0) sa = $urandom_range(0, len - 1);
      else sa = -1;
      sweep($sformatf("rnd%0d", it), m, dw, c, sa);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
